// File: rtl/pio_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pio_cmd_arbiter
// Description : Round-robin sharing of the single PIO command port among NREQ
//               requesters, with back-pressure stalls and a stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_cmd_arbiter #(
  parameter int         NREQ     = 4,
  parameter logic [3:0] ACT_PUSH = 4'd1,
  parameter logic [3:0] ACT_PULL = 4'd2,
  parameter int         TIMEOUT  = 1024
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_action,
  input  logic [5*NREQ-1:0]    req_index,
  input  logic [32*NREQ-1:0]   req_din,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_err,
  output logic [31:0]          rsp_data,
  output logic                 busy,
  output logic [1:0]           pio_mindex,
  output logic [4:0]           pio_index,
  output logic [31:0]          pio_din,
  output logic [3:0]           pio_action,
  input  logic [31:0]          pio_dout,
  input  logic [3:0]           pio_tx_full,
  input  logic [3:0]           pio_rx_empty
);

  localparam int              PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0]   RR_INIT = PW'(NREQ - 1);
  localparam logic [15:0]     TO_CNT  = 16'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;

  logic [NREQ-1:0] r_hold_valid;
  logic [3:0]      r_hold_act [NREQ];
  logic [4:0]      r_hold_idx [NREQ];
  logic [31:0]     r_hold_din [NREQ];

  logic [PW-1:0]   r_rr;
  logic [PW-1:0]   r_gnt;
  logic [PW-1:0]   w_gnt;
  logic [PW-1:0]   w_cand;
  logic            w_grant;

  logic [3:0]      r_act;
  logic [1:0]      r_mindex;
  logic [4:0]      r_index;
  logic [31:0]     r_din;
  logic [15:0]     r_stall;
  logic            r_err;

  logic            w_blocked;
  logic            w_timeout;
  logic [15:0]     w_stall_inc;

  // Scan downwards so the last hit is the nearest set bit after the pointer.
  always_comb begin
    w_gnt  = r_rr;
    w_cand = r_rr;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = PW'((int'(r_rr) + k) % NREQ);
      if (r_hold_valid[w_cand]) begin
        w_gnt = w_cand;
      end
    end
  end

  assign w_grant     = (r_state == S_IDLE) && enable && (|r_hold_valid);
  assign w_blocked   = ((r_act == ACT_PUSH) && pio_tx_full[r_mindex]) ||
                       ((r_act == ACT_PULL) && pio_rx_empty[r_mindex]);
  assign w_stall_inc = r_stall + 16'd1;
  assign w_timeout   = (TIMEOUT != 0) && (w_stall_inc == TO_CNT);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (!w_blocked)     w_state_nxt = S_ISSUE;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pio_action = 4'd0;
    rsp_valid  = '0;
    rsp_err    = 1'b0;
    rsp_data   = 32'd0;
    case (r_state)
      S_ISSUE: pio_action = r_act;
      S_RESP: begin
        rsp_valid[r_gnt] = 1'b1;
        rsp_err          = r_err;
        if ((r_act == ACT_PULL) && !r_err) rsp_data = pio_dout;
      end
      default: ;
    endcase
  end

  // Load and release never collide: a held slot is not reloadable until RESP frees it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_hold_valid <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_hold_act[i] <= 4'd0;
        r_hold_idx[i] <= 5'd0;
        r_hold_din[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !r_hold_valid[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_act[i]   <= req_action[4*i +: 4];
          r_hold_idx[i]   <= req_index[5*i +: 5];
          r_hold_din[i]   <= req_din[32*i +: 32];
        end else if ((r_state == S_RESP) && (int'(r_gnt) == i)) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rr     <= RR_INIT;
      r_gnt    <= '0;
      r_act    <= 4'd0;
      r_mindex <= 2'd0;
      r_index  <= 5'd0;
      r_din    <= 32'd0;
      r_stall  <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt    <= w_gnt;
        r_act    <= r_hold_act[w_gnt];
        r_mindex <= 2'(w_gnt);
        r_index  <= r_hold_idx[w_gnt];
        r_din    <= r_hold_din[w_gnt];
        r_stall  <= 16'd0;
        r_err    <= 1'b0;
      end
      if ((r_state == S_CHECK) && w_blocked) begin
        r_stall <= w_stall_inc;
        if (w_timeout) r_err <= 1'b1;
      end
      if (r_state == S_RESP) begin
        r_rr <= r_gnt;
      end
    end
  end

  assign req_ready  = ~r_hold_valid;
  assign busy       = (r_state != S_IDLE);
  assign pio_mindex = r_mindex;
  assign pio_index  = r_index;
  assign pio_din    = r_din;

endmodule
`default_nettype wire

// File: tb/tb_pio_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_cmd_arbiter
// Description : Directed self-checking bench for pio_cmd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_cmd_arbiter;

  localparam int NREQ = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [15:0]   req_action;
  logic [19:0]   req_index;
  logic [127:0]  req_din;
  logic [3:0]    rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_data;
  logic          busy;
  logic [1:0]    pio_mindex;
  logic [4:0]    pio_index;
  logic [31:0]   pio_din;
  logic [3:0]    pio_action;
  logic [31:0]   pio_dout;
  logic [3:0]    pio_tx_full;
  logic [3:0]    pio_rx_empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pio_cmd_arbiter #(
    .NREQ(NREQ), .ACT_PUSH(4'd1), .ACT_PULL(4'd2), .TIMEOUT(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_action(req_action),
    .req_index(req_index), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
    .pio_mindex(pio_mindex), .pio_index(pio_index), .pio_din(pio_din),
    .pio_action(pio_action), .pio_dout(pio_dout),
    .pio_tx_full(pio_tx_full), .pio_rx_empty(pio_rx_empty)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] act, input logic [4:0] idx,
                         input logic [31:0] d);
    req_valid[i]         = 1'b1;
    req_action[4*i +: 4] = act;
    req_index[5*i +: 5]  = idx;
    req_din[32*i +: 32]  = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; req_valid = 4'h0; req_action = '0; req_index = '0;
    req_din = '0; pio_dout = 32'h0; pio_tx_full = 4'h0; pio_rx_empty = 4'h0;
    repeat (2) step;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready got %h want F", req_ready); end
    n_checks++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); end
    n_checks++; if (pio_action !== 4'h0) begin n_fail++; $display("FAIL reset_action got %h want 0", pio_action); end
    n_checks++; if ({pio_mindex, pio_index, pio_din} !== 39'd0) begin n_fail++; $display("FAIL reset_pio got %h/%h/%h want 0", pio_mindex, pio_index, pio_din); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_push;
    int n_act = 0, act_step = -1, rsp_step = -1;
    logic [3:0] a = 4'h0, rv = 4'h0; logic [1:0] mi = 2'd3; logic [4:0] ix = 5'd0;
    logic [31:0] dn = 32'h0, rd = 32'hFFFF_FFFF; logic er = 1'b1;
    pio_dout = 32'hDEADBEEF;
    set_req(0, 4'd1, 5'd7, 32'h12345678);
    for (int k = 1; k <= 12; k++) begin
      step;
      if (pio_action !== 4'h0) begin n_act++; act_step = k; a = pio_action; mi = pio_mindex; ix = pio_index; dn = pio_din; end
      if (rsp_valid !== 4'h0) begin rsp_step = k; rv = rsp_valid; er = rsp_err; rd = rsp_data; end
      if (k == 1) req_valid = 4'h0;
    end
    n_checks++; if (n_act != 1 || a !== 4'd1) begin n_fail++; $display("FAIL push_pulse got %0d pulses act %h want 1 pulse act 1", n_act, a); end
    n_checks++; if (act_step != 3) begin n_fail++; $display("FAIL push_issue_cycle got %0d want 3", act_step); end
    n_checks++; if (mi !== 2'd0 || ix !== 5'd7 || dn !== 32'h12345678) begin n_fail++; $display("FAIL push_fields got %h/%h/%h want 0/07/12345678", mi, ix, dn); end
    n_checks++; if (rsp_step != 4 || rv !== 4'b0001) begin n_fail++; $display("FAIL push_rsp got step %0d bits %b want 4 0001", rsp_step, rv); end
    n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL push_rsp_data got err %b data %h want 0 0", er, rd); end
    n_checks++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL push_ready_after got %h want F", req_ready); end
  endtask

  task automatic test_pull_stall;
    int n_act = 0, act_step = -1, rsp_step = -1;
    logic [3:0] a = 4'h0, rv = 4'h0; logic [1:0] mi = 2'd0; logic [31:0] rd = 32'h0;
    logic er = 1'b1, busy7 = 1'b0;
    pio_rx_empty = 4'b0100; pio_dout = 32'hCAFEF00D;
    set_req(2, 4'd2, 5'd9, 32'h0);
    for (int k = 1; k <= 25; k++) begin
      step;
      if (pio_action !== 4'h0) begin n_act++; act_step = k; a = pio_action; mi = pio_mindex; end
      if (rsp_valid !== 4'h0) begin rsp_step = k; rv = rsp_valid; er = rsp_err; rd = rsp_data; end
      if (k == 7) busy7 = busy;
      if (k == 1) req_valid = 4'h0;
      if (k == 12) pio_rx_empty = 4'h0;
    end
    n_checks++; if (busy7 !== 1'b1) begin n_fail++; $display("FAIL pull_busy_stall got %b want 1", busy7); end
    n_checks++; if (n_act != 1 || a !== 4'd2 || mi !== 2'd2) begin n_fail++; $display("FAIL pull_pulse got %0d pulses act %h m %h want 1 2 2", n_act, a, mi); end
    n_checks++; if (act_step != 13) begin n_fail++; $display("FAIL pull_issue_cycle got %0d want 13", act_step); end
    n_checks++; if (rsp_step != 14 || rv !== 4'b0100) begin n_fail++; $display("FAIL pull_rsp got step %0d bits %b want 14 0100", rsp_step, rv); end
    n_checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin n_fail++; $display("FAIL pull_data got %h err %b want CAFEF00D 0", rd, er); end
  endtask

  task automatic test_round_robin;
    logic [3:0] ord [8];
    logic [3:0] exp_ord [5];
    int n = 0, sentk = -1;
    logic got0 = 1'b0, sent0 = 1'b0;
    exp_ord[0] = 4'b0001; exp_ord[1] = 4'b0010; exp_ord[2] = 4'b0100;
    exp_ord[3] = 4'b1000; exp_ord[4] = 4'b0001;
    for (int i = 0; i < 8; i++) ord[i] = 4'h0;
    rst = 1'b1; step; rst = 1'b0; step;
    for (int i = 0; i < 4; i++) set_req(i, 4'd0, 5'(i), 32'(i));
    for (int k = 1; k <= 40; k++) begin
      step;
      if (rsp_valid !== 4'h0 && n < 8) begin ord[n] = rsp_valid; n++; end
      if (rsp_valid[0] === 1'b1) got0 = 1'b1;
      if (k == 1) req_valid = 4'h0;
      if (got0 && !sent0 && req_ready[0] === 1'b1) begin
        set_req(0, 4'd0, 5'd31, 32'h0); sent0 = 1'b1; sentk = k;
      end else if (sent0 && k == sentk + 1) begin
        req_valid[0] = 1'b0;
      end
    end
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL rr_count got %0d want 5", n); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ord[i] !== exp_ord[i]) begin n_fail++; $display("FAIL rr_order[%0d] got %b want %b", i, ord[i], exp_ord[i]); end
    end
  endtask

  task automatic test_timeout;
    int n_act = 0, rsp_step = -1;
    logic [3:0] rv = 4'h0; logic er = 1'b0; logic [31:0] rd = 32'hFFFF_FFFF; logic busy17 = 1'b0;
    pio_tx_full = 4'b0010; pio_dout = 32'h1111_2222;
    set_req(1, 4'd1, 5'd2, 32'hA5A5A5A5);
    for (int k = 1; k <= 30; k++) begin
      step;
      if (pio_action !== 4'h0) n_act++;
      if (rsp_valid !== 4'h0) begin rsp_step = k; rv = rsp_valid; er = rsp_err; rd = rsp_data; end
      if (k == 17) busy17 = busy;
      if (k == 1) req_valid = 4'h0;
    end
    pio_tx_full = 4'h0;
    n_checks++; if (n_act != 0) begin n_fail++; $display("FAIL to_no_issue got %0d pulses want 0", n_act); end
    n_checks++; if (busy17 !== 1'b1) begin n_fail++; $display("FAIL to_busy_stall got %b want 1", busy17); end
    n_checks++; if (rsp_step != 18 || rv !== 4'b0010) begin n_fail++; $display("FAIL to_rsp got step %0d bits %b want 18 0010", rsp_step, rv); end
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL to_err got err %b data %h want 1 0", er, rd); end
  endtask

  task automatic test_reset_mid;
    int rsp_cnt = 0, busy_cnt = 0;
    pio_tx_full = 4'b0010;
    set_req(1, 4'd1, 5'd21, 32'h5A5A0001);
    for (int k = 1; k <= 4; k++) begin
      step;
      if (k == 1) req_valid = 4'h0;
    end
    n_checks++; if (busy !== 1'b1 || pio_mindex !== 2'd1) begin n_fail++; $display("FAIL rmid_pre got busy %b m %h want 1 1", busy, pio_mindex); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || pio_action !== 4'h0) begin n_fail++; $display("FAIL rmid_busy got %b act %h want 0 0", busy, pio_action); end
    n_checks++; if ({pio_mindex, pio_index, pio_din} !== 39'd0) begin n_fail++; $display("FAIL rmid_pio got %h/%h/%h want 0", pio_mindex, pio_index, pio_din); end
    n_checks++; if (rsp_valid !== 4'h0 || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin n_fail++; $display("FAIL rmid_rsp got %b/%b/%h want 0", rsp_valid, rsp_err, rsp_data); end
    n_checks++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL rmid_ready got %h want F", req_ready); end
    #1 rst = 1'b0;
    pio_tx_full = 4'h0;
    for (int k = 1; k <= 15; k++) begin
      step;
      if (rsp_valid !== 4'h0) rsp_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    n_checks++; if (rsp_cnt != 0 || busy_cnt != 0) begin n_fail++; $display("FAIL rmid_after got rsp %0d busy %0d want 0 0", rsp_cnt, busy_cnt); end
  endtask

  task automatic test_enable;
    int rsp_cnt = 0, busy_cnt = 0, busy_step = -1, rsp_step = -1;
    logic [3:0] rv = 4'h0;
    enable = 1'b0;
    set_req(3, 4'd0, 5'd4, 32'h3);
    for (int k = 1; k <= 20; k++) begin
      step;
      if (busy === 1'b1) busy_cnt++;
      if (rsp_valid !== 4'h0) rsp_cnt++;
      if (k == 1) req_valid = 4'h0;
    end
    n_checks++; if (busy_cnt != 0 || rsp_cnt != 0) begin n_fail++; $display("FAIL en_off got busy %0d rsp %0d want 0 0", busy_cnt, rsp_cnt); end
    n_checks++; if (req_ready !== 4'b0111) begin n_fail++; $display("FAIL en_pending got %b want 0111", req_ready); end
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step;
      if (busy === 1'b1 && busy_step < 0) busy_step = k;
      if (rsp_valid !== 4'h0) begin rsp_step = k; rv = rsp_valid; end
      if (k == 1) enable = 1'b0;
    end
    n_checks++; if (busy_step != 1) begin n_fail++; $display("FAIL en_grant got step %0d want 1", busy_step); end
    n_checks++; if (rsp_step != 3 || rv !== 4'b1000) begin n_fail++; $display("FAIL en_rsp got step %0d bits %b want 3 1000", rsp_step, rv); end
  endtask

  initial begin
    test_reset;
    test_push;
    test_pull_stall;
    test_round_robin;
    test_timeout;
    test_reset_mid;
    test_enable;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
